// File: rtl/proc_mem_arbiter_pkg.sv
// Message types for the 4-byte processor/memory request and response channels.
package proc_mem_arbiter_pkg;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/proc_mem_arbiter_if.sv
// Request/response handshake bundle between a memory requester (master) and a memory (slave).
interface proc_mem_arbiter_if;
    import proc_mem_arbiter_pkg::*;

    mem_req_4B_t  req_msg;
    logic         req_val;
    logic         req_rdy;
    mem_resp_4B_t resp_msg;
    logic         resp_val;
    logic         resp_rdy;

    modport master (
        output req_msg, req_val, resp_rdy,
        input  req_rdy, resp_msg, resp_val
    );

    modport slave (
        input  req_msg, req_val, resp_rdy,
        output req_rdy, resp_msg, resp_val
    );
endinterface

// File: rtl/proc_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between dmem (requester 0) and imem (1).
// A tracking FIFO remembers owner and opaque of each in-flight request to route responses back.
module proc_mem_arbiter
    import proc_mem_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    proc_mem_arbiter_if.slave                dmem,
    proc_mem_arbiter_if.slave                imem,
    proc_mem_arbiter_if.master               mem,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic          prio;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [8:0]    track_q [MAX_OUTSTANDING];

    logic         can_issue;
    logic         candidate;
    logic         req_fire;
    logic         resp_fire;
    logic         fifo_empty;
    logic         head_owner;
    logic [7:0]   head_opaque;
    logic [7:0]   cand_opaque;
    mem_req_4B_t  req_sel;
    mem_resp_4B_t resp_routed;

    // Registered count only: a pop in the same cycle does not free a slot for a push.
    assign can_issue   = count < CW'(MAX_OUTSTANDING);
    assign candidate   = (dmem.req_val && imem.req_val) ? prio : imem.req_val;
    assign cand_opaque = candidate ? imem.req_msg.opaque : dmem.req_msg.opaque;

    always_comb begin
        req_sel        = candidate ? imem.req_msg : dmem.req_msg;
        req_sel.opaque = '0;
    end

    assign mem.req_msg  = req_sel;
    assign mem.req_val  = can_issue && (dmem.req_val || imem.req_val);
    assign dmem.req_rdy = !candidate && can_issue && mem.req_rdy;
    assign imem.req_rdy = candidate && can_issue && mem.req_rdy;
    assign req_fire     = mem.req_val && mem.req_rdy;

    assign fifo_empty  = (count == '0);
    assign head_owner  = track_q[head][8];
    assign head_opaque = track_q[head][7:0];

    always_comb begin
        resp_routed        = mem.resp_msg;
        resp_routed.opaque = head_opaque;
    end

    assign dmem.resp_msg  = resp_routed;
    assign imem.resp_msg  = resp_routed;
    assign dmem.resp_val  = !fifo_empty && !head_owner && mem.resp_val;
    assign imem.resp_val  = !fifo_empty && head_owner && mem.resp_val;
    assign mem.resp_rdy   = !fifo_empty && (head_owner ? imem.resp_rdy : dmem.resp_rdy);
    assign resp_fire      = mem.resp_val && mem.resp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio  <= 1'b0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (req_fire) begin
                prio <= ~candidate;
                tail <= tail + 1'b1;
            end
            if (resp_fire) begin
                head <= head + 1'b1;
            end
            case ({req_fire, resp_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entries need no reset: they are only read while the FIFO holds them.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            track_q[tail] <= {candidate, cand_opaque};
        end
    end

    assign outstanding = count;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Self-checking bench for proc_mem_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_proc_mem_arbiter;
    import proc_mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] outstanding;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    proc_mem_arbiter_if dmem_bus ();
    proc_mem_arbiter_if imem_bus ();
    proc_mem_arbiter_if mem_bus ();

    proc_mem_arbiter #(.MAX_OUTSTANDING(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .dmem        (dmem_bus.slave),
        .imem        (imem_bus.slave),
        .mem         (mem_bus.master),
        .outstanding (outstanding)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic mem_req_4B_t mk_req(logic [7:0] op, logic [31:0] addr);
        mem_req_4B_t r;
        r.msg_type = 3'd0;
        r.opaque   = op;
        r.addr     = addr;
        r.len      = 2'd0;
        r.data     = 32'h0;
        return r;
    endfunction

    function automatic mem_resp_4B_t mk_resp(logic [7:0] op, logic [31:0] data);
        mem_resp_4B_t r;
        r.msg_type = 3'd0;
        r.opaque   = op;
        r.test     = 2'd0;
        r.len      = 2'd0;
        r.data     = data;
        return r;
    endfunction

    function automatic mem_req_4B_t rand_req();
        mem_req_4B_t r;
        r.msg_type = 3'($urandom_range(0, 1));
        r.opaque   = 8'($urandom);
        r.addr     = $urandom;
        r.len      = 2'($urandom);
        r.data     = $urandom;
        return r;
    endfunction

    function automatic mem_resp_4B_t rand_resp();
        mem_resp_4B_t r;
        r.msg_type = 3'($urandom_range(0, 1));
        r.opaque   = 8'($urandom);
        r.test     = 2'($urandom);
        r.len      = 2'($urandom);
        r.data     = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        dmem_bus.req_val  = 1'b0;
        dmem_bus.req_msg  = mk_req(8'h0, 32'h0);
        dmem_bus.resp_rdy = 1'b1;
        imem_bus.req_val  = 1'b0;
        imem_bus.req_msg  = mk_req(8'h0, 32'h0);
        imem_bus.resp_rdy = 1'b1;
        mem_bus.req_rdy   = 1'b1;
        mem_bus.resp_val  = 1'b0;
        mem_bus.resp_msg  = mk_resp(8'h0, 32'h0);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        dmem_bus.req_val  = 1'b0;
        imem_bus.req_val  = 1'b0;
        dmem_bus.resp_rdy = 1'b1;
        imem_bus.resp_rdy = 1'b1;
        for (int k = 0; k < 20 && outstanding != '0; k++) begin
            mem_bus.resp_val = 1'b1;
            @(negedge clk);
        end
        mem_bus.resp_val = 1'b0;
        #1;
        checks++; if (outstanding !== '0) begin failures++; $display("FAIL drain_empty: outstanding=%0d want 0", outstanding); end
    endtask

    task automatic test_reset();
        do_reset();
        mem_bus.resp_val = 1'b1;
        #1;
        checks++; if (outstanding !== '0) begin failures++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if (mem_bus.req_val !== 1'b0) begin failures++; $display("FAIL reset_memreq_val: got %b want 0", mem_bus.req_val); end
        checks++; if (mem_bus.resp_rdy !== 1'b0) begin failures++; $display("FAIL empty_memresp_rdy: got %b want 0", mem_bus.resp_rdy); end
        checks++; if (dmem_bus.resp_val !== 1'b0 || imem_bus.resp_val !== 1'b0) begin
            failures++; $display("FAIL empty_resp_val: d=%b i=%b want 0 0", dmem_bus.resp_val, imem_bus.resp_val); end
        @(negedge clk);
        mem_bus.resp_val = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        dmem_bus.req_val = 1'b1;
        dmem_bus.req_msg = mk_req(8'h5A, 32'h100);
        #1;
        checks++; if (mem_bus.req_val !== 1'b1) begin failures++; $display("FAIL single_memreq_val: got %b want 1", mem_bus.req_val); end
        checks++; if (mem_bus.req_msg.addr !== 32'h100) begin failures++; $display("FAIL single_addr: got %h want 00000100", mem_bus.req_msg.addr); end
        checks++; if (mem_bus.req_msg.opaque !== 8'h00) begin failures++; $display("FAIL single_req_opaque: got %h want 00", mem_bus.req_msg.opaque); end
        checks++; if (dmem_bus.req_rdy !== 1'b1 || imem_bus.req_rdy !== 1'b0) begin
            failures++; $display("FAIL single_rdy: d=%b i=%b want 1 0", dmem_bus.req_rdy, imem_bus.req_rdy); end
        @(negedge clk);
        dmem_bus.req_val = 1'b0;
        mem_bus.resp_val = 1'b1;
        mem_bus.resp_msg = mk_resp(8'h00, 32'hDEADBEEF);
        #1;
        checks++; if (outstanding !== CW'(1)) begin failures++; $display("FAIL single_outstanding1: got %0d want 1", outstanding); end
        checks++; if (dmem_bus.resp_val !== 1'b1 || imem_bus.resp_val !== 1'b0) begin
            failures++; $display("FAIL single_resp_val: d=%b i=%b want 1 0", dmem_bus.resp_val, imem_bus.resp_val); end
        checks++; if (dmem_bus.resp_msg.data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_resp_data: got %h want deadbeef", dmem_bus.resp_msg.data); end
        checks++; if (dmem_bus.resp_msg.opaque !== 8'h5A) begin failures++; $display("FAIL single_resp_opaque: got %h want 5a", dmem_bus.resp_msg.opaque); end
        checks++; if (mem_bus.resp_rdy !== 1'b1) begin failures++; $display("FAIL single_memresp_rdy: got %b want 1", mem_bus.resp_rdy); end
        @(negedge clk);
        mem_bus.resp_val = 1'b0;
        #1;
        checks++; if (outstanding !== '0) begin failures++; $display("FAIL single_outstanding0: got %0d want 0", outstanding); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int d_fires = 0;
        int i_fires = 0;
        do_reset();
        dmem_bus.req_val = 1'b1;
        dmem_bus.req_msg = mk_req(8'h11, 32'h300);
        imem_bus.req_val = 1'b1;
        imem_bus.req_msg = mk_req(8'h22, 32'h400);
        for (int i = 0; i < 6; i++) begin
            mem_bus.resp_val = (i > 0);
            #1;
            checks++; if (dmem_bus.req_rdy !== (i % 2 == 0) || imem_bus.req_rdy !== (i % 2 == 1)) begin
                failures++; $display("FAIL rr_grant%0d: d=%b i=%b want %b %b", i, dmem_bus.req_rdy, imem_bus.req_rdy, i % 2 == 0, i % 2 == 1); end
            checks++; if (mem_bus.req_msg.addr !== ((i % 2 == 0) ? 32'h300 : 32'h400)) begin
                failures++; $display("FAIL rr_addr%0d: got %h", i, mem_bus.req_msg.addr); end
            if (dmem_bus.req_rdy) d_fires++;
            if (imem_bus.req_rdy) i_fires++;
            @(negedge clk);
        end
        checks++; if (d_fires != 3 || i_fires != 3) begin failures++; $display("FAIL rr_fire_counts: d=%0d i=%0d want 3 3", d_fires, i_fires); end
        drain();
    endtask

    task automatic test_full_fifo();
        do_reset();
        imem_bus.req_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imem_bus.req_msg = mk_req(8'(k), 32'h200 + 32'(4 * k));
            #1;
            checks++; if (imem_bus.req_rdy !== 1'b1) begin failures++; $display("FAIL full_issue%0d: rdy=%b want 1", k, imem_bus.req_rdy); end
            @(negedge clk);
        end
        imem_bus.req_msg = mk_req(8'h04, 32'h210);
        #1;
        checks++; if (imem_bus.req_rdy !== 1'b0 || mem_bus.req_val !== 1'b0) begin
            failures++; $display("FAIL full_block: rdy=%b memreq_val=%b want 0 0", imem_bus.req_rdy, mem_bus.req_val); end
        checks++; if (outstanding !== CW'(4)) begin failures++; $display("FAIL full_outstanding4: got %0d want 4", outstanding); end
        @(negedge clk);
        mem_bus.resp_val = 1'b1;
        mem_bus.resp_msg = mk_resp(8'h00, 32'h1234);
        #1;
        checks++; if (imem_bus.resp_val !== 1'b1 || imem_bus.resp_msg.opaque !== 8'h00) begin
            failures++; $display("FAIL full_pop_resp: val=%b op=%h want 1 00", imem_bus.resp_val, imem_bus.resp_msg.opaque); end
        checks++; if (imem_bus.req_rdy !== 1'b0) begin failures++; $display("FAIL full_push_during_pop: rdy=%b want 0", imem_bus.req_rdy); end
        @(negedge clk);
        mem_bus.resp_val = 1'b0;
        #1;
        checks++; if (outstanding !== CW'(3)) begin failures++; $display("FAIL full_after_pop: got %0d want 3", outstanding); end
        checks++; if (imem_bus.req_rdy !== 1'b1 || mem_bus.req_msg.addr !== 32'h210) begin
            failures++; $display("FAIL full_fifth_issue: rdy=%b addr=%h want 1 00000210", imem_bus.req_rdy, mem_bus.req_msg.addr); end
        @(negedge clk);
        imem_bus.req_val = 1'b0;
        #1;
        checks++; if (outstanding !== CW'(4)) begin failures++; $display("FAIL full_refill: got %0d want 4", outstanding); end
        @(negedge clk);
        drain();
    endtask

    task automatic test_order();
        logic [31:0] rdata [3];
        logic        rown  [3];
        logic [7:0]  rop   [3];
        rdata[0] = 32'hA; rdata[1] = 32'hB; rdata[2] = 32'hC;
        rown[0]  = 1'b0;  rown[1]  = 1'b1;  rown[2]  = 1'b0;
        rop[0]   = 8'h01; rop[1]   = 8'h02; rop[2]   = 8'h03;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            dmem_bus.req_val = !rown[k];
            imem_bus.req_val = rown[k];
            dmem_bus.req_msg = mk_req(rop[k], 32'h10 + 32'(k));
            imem_bus.req_msg = mk_req(rop[k], 32'h10 + 32'(k));
            @(negedge clk);
        end
        dmem_bus.req_val = 1'b0;
        imem_bus.req_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_bus.resp_val = 1'b1;
            mem_bus.resp_msg = mk_resp(8'hEE, rdata[k]);
            #1;
            checks++; if (dmem_bus.resp_val !== !rown[k] || imem_bus.resp_val !== rown[k]) begin
                failures++; $display("FAIL order_owner%0d: d=%b i=%b want %b %b", k, dmem_bus.resp_val, imem_bus.resp_val, !rown[k], rown[k]); end
            checks++; if ((rown[k] ? imem_bus.resp_msg.opaque : dmem_bus.resp_msg.opaque) !== rop[k] ||
                          (rown[k] ? imem_bus.resp_msg.data : dmem_bus.resp_msg.data) !== rdata[k]) begin
                failures++; $display("FAIL order_msg%0d: op=%h data=%h want %h %h", k, rown[k] ? imem_bus.resp_msg.opaque : dmem_bus.resp_msg.opaque,
                                     rown[k] ? imem_bus.resp_msg.data : dmem_bus.resp_msg.data, rop[k], rdata[k]); end
            @(negedge clk);
        end
        mem_bus.resp_val = 1'b0;
        #1;
        checks++; if (outstanding !== '0) begin failures++; $display("FAIL order_empty: got %0d want 0", outstanding); end
        @(negedge clk);
    endtask

    task automatic test_resp_stall();
        do_reset();
        dmem_bus.req_val = 1'b1;
        dmem_bus.req_msg = mk_req(8'h44, 32'h500);
        @(negedge clk);
        dmem_bus.req_val = 1'b0;
        imem_bus.req_val = 1'b1;
        imem_bus.req_msg = mk_req(8'h55, 32'h600);
        @(negedge clk);
        imem_bus.req_val  = 1'b0;
        dmem_bus.resp_rdy = 1'b0;
        mem_bus.resp_val  = 1'b1;
        mem_bus.resp_msg  = mk_resp(8'h00, 32'h77);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (mem_bus.resp_rdy !== 1'b0 || dmem_bus.resp_val !== 1'b1 || imem_bus.resp_val !== 1'b0) begin
                failures++; $display("FAIL stall%0d: memresp_rdy=%b d=%b i=%b want 0 1 0", k, mem_bus.resp_rdy, dmem_bus.resp_val, imem_bus.resp_val); end
            checks++; if (outstanding !== CW'(2)) begin failures++; $display("FAIL stall_count%0d: got %0d want 2", k, outstanding); end
            @(negedge clk);
        end
        dmem_bus.resp_rdy = 1'b1;
        #1;
        checks++; if (mem_bus.resp_rdy !== 1'b1 || dmem_bus.resp_msg.opaque !== 8'h44) begin
            failures++; $display("FAIL stall_release: rdy=%b op=%h want 1 44", mem_bus.resp_rdy, dmem_bus.resp_msg.opaque); end
        @(negedge clk);
        mem_bus.resp_msg = mk_resp(8'h00, 32'h88);
        #1;
        checks++; if (outstanding !== CW'(1)) begin failures++; $display("FAIL stall_single_pop: got %0d want 1", outstanding); end
        checks++; if (imem_bus.resp_val !== 1'b1 || dmem_bus.resp_val !== 1'b0 || imem_bus.resp_msg.opaque !== 8'h55) begin
            failures++; $display("FAIL stall_next_owner: i=%b d=%b op=%h want 1 0 55", imem_bus.resp_val, dmem_bus.resp_val, imem_bus.resp_msg.opaque); end
        @(negedge clk);
        drain();
    endtask

    // Reference model: an in-order queue of {owner, opaque} plus the round-robin favourite.
    task automatic test_random();
        logic [8:0]   m_q [$];
        logic         m_prio = 1'b0;
        int           pend = 0;
        logic         dh = 1'b0, ih = 1'b0, mh = 1'b0;
        logic         dv, iv, can, cand, e_mval, e_crdy, e_rrdy, own, req_fire, resp_fire;
        mem_req_4B_t  e_req;
        mem_resp_4B_t e_resp;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (!dh) begin dmem_bus.req_val = ($urandom_range(0, 2) != 0); dmem_bus.req_msg = rand_req(); end
            if (!ih) begin imem_bus.req_val = ($urandom_range(0, 2) != 0); imem_bus.req_msg = rand_req(); end
            dmem_bus.resp_rdy = ($urandom_range(0, 3) != 0);
            imem_bus.resp_rdy = ($urandom_range(0, 3) != 0);
            mem_bus.req_rdy   = ($urandom_range(0, 3) != 0);
            if (!mh) begin mem_bus.resp_val = (pend > 0) && ($urandom_range(0, 1) == 1); mem_bus.resp_msg = rand_resp(); end
            #1;
            dv     = dmem_bus.req_val;
            iv     = imem_bus.req_val;
            can    = m_q.size() < N;
            cand   = (dv && iv) ? m_prio : iv;
            e_mval = can && (dv || iv);
            e_crdy = can && mem_bus.req_rdy;
            e_req  = cand ? imem_bus.req_msg : dmem_bus.req_msg;
            e_req.opaque = 8'h00;
            checks++; if (outstanding !== CW'(m_q.size())) begin failures++; $display("FAIL rnd_outstanding c%0d: got %0d want %0d", c, outstanding, m_q.size()); end
            checks++; if (mem_bus.req_val !== e_mval) begin failures++; $display("FAIL rnd_memreq_val c%0d: got %b want %b", c, mem_bus.req_val, e_mval); end
            if (dv) begin
                checks++; if (dmem_bus.req_rdy !== (!cand && e_crdy)) begin failures++; $display("FAIL rnd_drdy c%0d: got %b want %b", c, dmem_bus.req_rdy, !cand && e_crdy); end
            end
            if (iv) begin
                checks++; if (imem_bus.req_rdy !== (cand && e_crdy)) begin failures++; $display("FAIL rnd_irdy c%0d: got %b want %b", c, imem_bus.req_rdy, cand && e_crdy); end
            end
            if (e_mval) begin
                checks++; if (mem_bus.req_msg !== e_req) begin failures++; $display("FAIL rnd_memreq_msg c%0d: got %h want %h", c, mem_bus.req_msg, e_req); end
            end
            if (m_q.size() == 0) begin
                e_rrdy = 1'b0;
                checks++; if (mem_bus.resp_rdy !== 1'b0 || dmem_bus.resp_val !== 1'b0 || imem_bus.resp_val !== 1'b0) begin
                    failures++; $display("FAIL rnd_empty c%0d: rdy=%b d=%b i=%b want 0 0 0", c, mem_bus.resp_rdy, dmem_bus.resp_val, imem_bus.resp_val); end
            end else begin
                own    = m_q[0][8];
                e_rrdy = own ? imem_bus.resp_rdy : dmem_bus.resp_rdy;
                e_resp = mem_bus.resp_msg;
                e_resp.opaque = m_q[0][7:0];
                checks++; if (mem_bus.resp_rdy !== e_rrdy) begin failures++; $display("FAIL rnd_memresp_rdy c%0d: got %b want %b", c, mem_bus.resp_rdy, e_rrdy); end
                checks++; if (dmem_bus.resp_val !== (!own && mem_bus.resp_val) || imem_bus.resp_val !== (own && mem_bus.resp_val)) begin
                    failures++; $display("FAIL rnd_resp_val c%0d: d=%b i=%b owner=%b", c, dmem_bus.resp_val, imem_bus.resp_val, own); end
                if (mem_bus.resp_val) begin
                    checks++; if ((own ? imem_bus.resp_msg : dmem_bus.resp_msg) !== e_resp) begin
                        failures++; $display("FAIL rnd_resp_msg c%0d: got %h want %h", c, own ? imem_bus.resp_msg : dmem_bus.resp_msg, e_resp); end
                end
            end
            req_fire  = e_mval && mem_bus.req_rdy;
            resp_fire = mem_bus.resp_val && e_rrdy;
            if (resp_fire) begin void'(m_q.pop_front()); pend--; end
            if (req_fire) begin
                m_q.push_back({cand, cand ? imem_bus.req_msg.opaque : dmem_bus.req_msg.opaque});
                m_prio = ~cand;
                pend++;
            end
            dh = dv && !(req_fire && !cand);
            ih = iv && !(req_fire && cand);
            mh = mem_bus.resp_val && !resp_fire;
            @(negedge clk);
        end
        drain();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_round_robin();
        test_full_fifo();
        test_order();
        test_resp_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_mem_arbiter.md
Name: proc_mem_arbiter

Overview:
- Shares one downstream memory request/response port between the processor's data-memory port (requester 0) and instruction-memory port (requester 1).
- Sits between the processor datapath/control and a single-ported test memory.
- Arbitrates requests with round-robin priority.
- Records the owner and original opaque field of every outstanding request in an in-order tracking FIFO, then routes each response back to the correct requester with its opaque field restored.
- The downstream memory always returns responses in request order.

Parameters:
- MAX_OUTSTANDING, 4, depth of the tracking FIFO (power of two, ≥2); maximum in-flight requests.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- dmemreq_msg  input  mem_req_4B_t  requester 0 request
- dmemreq_val  input  1  requester 0 request valid
- dmemreq_rdy  output  1  requester 0 request ready
- dmemresp_msg  output  mem_resp_4B_t  requester 0 response
- dmemresp_val  output  1  requester 0 response valid
- dmemresp_rdy  input  1  requester 0 response ready
- imemreq_msg / imemreq_val / imemreq_rdy  in/in/out  mem_req_4B_t/1/1  requester 1 request
- imemresp_msg / imemresp_val / imemresp_rdy  out/out/in  mem_resp_4B_t/1/1  requester 1 response
- memreq_msg  output  mem_req_4B_t  downstream request
- memreq_val  output  1  downstream request valid
- memreq_rdy  input  1  downstream request ready
- memresp_msg  input  mem_resp_4B_t  downstream response
- memresp_val  input  1  downstream response valid
- memresp_rdy  output  1  downstream response ready
- outstanding  output  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy (stats)

Behaviour:
- A transfer fires when val && rdy on the same cycle. All req/resp paths are combinational; no added latency.
- State:
  - prio: 1 bit, resets to 0 (dmem favoured).
  - Tracking FIFO: MAX_OUTSTANDING entries of {owner 1b, opaque 8b}, with head/tail pointers and a count.
  - On reset, all pointers and count clear to 0. Any in-flight transactions are abandoned; the bench must not issue reset mid-transaction unless the memory is reset too.
- Grant, computed each cycle:
  - can_issue = (count < MAX_OUTSTANDING).
  - If only one requester is valid, it is the candidate.
  - If both are valid, candidate = prio.
  - memreq_val = can_issue && (dmemreq_val || imemreq_val).
  - memreq_msg = candidate's msg with the opaque field replaced by 0. All other fields pass unchanged.
  - The candidate's req_rdy = can_issue && memreq_rdy. The non-candidate's rdy = 0.
- On request fire:
  - Push {candidate, original opaque} at the tail.
  - prio <= ~candidate. This happens on every fire, including uncontested ones.
- Response routing:
  - If the FIFO is empty: memresp_rdy = 0 and both resp_val = 0.
  - Otherwise owner = head.owner. The owner's resp_val = memresp_val, and its resp_msg = memresp_msg with opaque = head.opaque. The other resp_val = 0.
  - memresp_rdy = owner's resp_rdy.
- On response fire: pop the head.
- Simultaneous push and pop:
  - count is unchanged; both pointers advance.
  - When count == MAX_OUTSTANDING, a push is blocked even if a pop occurs the same cycle. can_issue uses the registered count only.
- Pointers wrap modulo MAX_OUTSTANDING.
- outstanding = count. It is 0 after reset and never exceeds MAX_OUTSTANDING.
- Requester msg fields may change while val is low. While val is high and rdy is low, requesters hold msg stable; the arbiter relies on this.
- A requester whose request is not granted is held off; the arbiter never drops a request.
- If the downstream memory holds memresp_val while the owner is not ready, the response stays stalled. Responses for the other requester never bypass the head.

Test Plan:
- Reset, then dmem-only read addr 0x100, opaque 0x5A; memory responds data 0xDEADBEEF next cycle -> memreq addr 0x100 with opaque 0; dmemresp_val with data 0xDEADBEEF, opaque 0x5A; imemresp_val stays 0; outstanding goes 1 then 0.
- Both valid continuously, memreq_rdy=1, 6 cycles -> grants alternate dmem, imem, dmem, imem, dmem, imem (prio starts 0); each requester sees exactly 3 fires.
- memreq_rdy=1, memory stalls responses (memresp_val=0), imem issues 5 back-to-back fetches with MAX_OUTSTANDING=4 -> 4 fires, then imemreq_rdy=0; outstanding=4; one response popped -> imemreq_rdy asserts next cycle and the 5th issues.
- Interleaved issue dmem(op 0x01), imem(op 0x02), dmem(op 0x03); in-order responses data 0xA, 0xB, 0xC -> dmem gets 0xA/0x01 and 0xC/0x03, imem gets 0xB/0x02; order preserved.
- Head owner dmem with dmemresp_rdy=0 for 3 cycles while memresp_val=1 -> memresp_rdy=0 for those cycles, no pop, imemresp_val=0; on dmemresp_rdy=1 a single pop occurs.
- Full FIFO (count=4) with a response popping and a new request valid on the same cycle -> pop occurs, no push that cycle, count=3; push occurs the following cycle, count returns to 4.
